// File: rtl/hpdcache_cfg_csr.sv
// rtl/hpdcache_cfg_csr.sv - HPDcache configuration register driver
// Shadow registers are copied to cfg_* only after the write buffer stays empty for QUIESCE_CYCLES.
module hpdcache_cfg_csr #(
  parameter int unsigned WBUF_TIMECNT_WIDTH = 3,
  parameter int unsigned SID_WIDTH          = 3,
  parameter int unsigned WBUF_THR_RST       = 3,
  parameter int unsigned QUIESCE_CYCLES     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_we_i,
  input  logic [1:0]                    req_addr_i,
  input  logic [31:0]                   req_wdata_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [31:0]                   rsp_rdata_o,
  output logic                          rsp_err_o,
  input  logic                          wbuf_empty_i,
  output logic                          cfg_enable_o,
  output logic [WBUF_TIMECNT_WIDTH-1:0] cfg_wbuf_threshold_o,
  output logic                          cfg_wbuf_reset_timecnt_on_write_o,
  output logic                          cfg_wbuf_sequential_waw_o,
  output logic                          cfg_wbuf_inhibit_write_coalescing_o,
  output logic                          cfg_hwpf_stride_updt_plru_o,
  output logic [SID_WIDTH-1:0]          cfg_hwpf_stride_sid_o,
  output logic                          cfg_error_on_cacheable_amo_o,
  output logic                          cfg_rtab_single_entry_o,
  output logic                          apply_pending_o
);

  typedef enum logic [1:0] {IDLE, WAIT, APPLY} state_t;

  localparam logic [WBUF_TIMECNT_WIDTH-1:0] THR_RST = WBUF_TIMECNT_WIDTH'(WBUF_THR_RST);
  localparam logic [7:0]                    QCYC    = 8'(QUIESCE_CYCLES);

  state_t                        state;
  logic [6:0]                    sh_ctrl, act_ctrl;
  logic [WBUF_TIMECNT_WIDTH-1:0] sh_thr, act_thr;
  logic [SID_WIDTH-1:0]          sh_sid, act_sid;
  logic [7:0]                    apply_cnt;
  logic [7:0]                    quiesce_cnt;
  logic                          rsp_valid_q;
  logic [31:0]                   rsp_rdata_q;
  logic                          rsp_err_q;
  logic                          accept;
  logic                          wr_cfg;
  logic [31:0]                   rd_data;
  logic                          unused_wdata;

  assign req_ready_o  = !rsp_valid_q;
  assign accept       = req_valid_i && req_ready_o;
  assign wr_cfg       = accept && req_we_i && (req_addr_i != 2'd3);
  assign unused_wdata = ^req_wdata_i;

  always_comb begin
    rd_data = '0;
    case (req_addr_i)
      2'd0: rd_data[6:0] = sh_ctrl;
      2'd1: rd_data[WBUF_TIMECNT_WIDTH-1:0] = sh_thr;
      2'd2: rd_data[SID_WIDTH-1:0] = sh_sid;
      default: begin
        rd_data[0]    = (state != IDLE);
        rd_data[1]    = wbuf_empty_i;
        rd_data[15:8] = apply_cnt;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      sh_ctrl     <= '0;
      act_ctrl    <= '0;
      sh_thr      <= THR_RST;
      act_thr     <= THR_RST;
      sh_sid      <= '0;
      act_sid     <= '0;
      apply_cnt   <= '0;
      quiesce_cnt <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= req_we_i ? 32'd0 : rd_data;
        rsp_err_q   <= req_we_i && (req_addr_i == 2'd3);
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end

      case (state)
        IDLE: ;
        WAIT: begin
          if (quiesce_cnt == QCYC) begin
            state       <= APPLY;
            quiesce_cnt <= '0;
          end else if (wbuf_empty_i) begin
            quiesce_cnt <= quiesce_cnt + 8'd1;
          end else begin
            quiesce_cnt <= '0;
          end
        end
        APPLY: begin
          act_ctrl  <= sh_ctrl;
          act_thr   <= sh_thr;
          act_sid   <= sh_sid;
          apply_cnt <= apply_cnt + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A new write restarts the quiesce window; in APPLY the old shadow has already been copied.
      if (wr_cfg) begin
        case (req_addr_i)
          2'd0:    sh_ctrl <= req_wdata_i[6:0];
          2'd1:    sh_thr  <= req_wdata_i[WBUF_TIMECNT_WIDTH-1:0];
          default: sh_sid  <= req_wdata_i[SID_WIDTH-1:0];
        endcase
        state       <= WAIT;
        quiesce_cnt <= '0;
      end
    end
  end

  assign rsp_valid_o                         = rsp_valid_q;
  assign rsp_rdata_o                         = rsp_rdata_q;
  assign rsp_err_o                           = rsp_err_q;
  assign apply_pending_o                     = (state != IDLE);
  assign cfg_enable_o                        = act_ctrl[0];
  assign cfg_wbuf_reset_timecnt_on_write_o   = act_ctrl[1];
  assign cfg_wbuf_sequential_waw_o           = act_ctrl[2];
  assign cfg_wbuf_inhibit_write_coalescing_o = act_ctrl[3];
  assign cfg_hwpf_stride_updt_plru_o         = act_ctrl[4];
  assign cfg_error_on_cacheable_amo_o        = act_ctrl[5];
  assign cfg_rtab_single_entry_o             = act_ctrl[6];
  assign cfg_wbuf_threshold_o                = act_thr;
  assign cfg_hwpf_stride_sid_o               = act_sid;

endmodule
